mem_burst_reader: RTL and testbench
===================================

Name: mem_burst_reader

Overview:
- Initiator for the single-port synchronous RAM interface (read/write enables, addr, one-cycle registered dataRead).
- Accepts a burst command (base, length, stride) and issues one RAM read per element.
- Returns the data as a valid/ready stream with a last marker, and absorbs downstream backpressure without losing data.
- Sits between the CGRA load path (or bench driver) and the memoryRAM instance.

Parameters:
- data_depth, 5, RAM address width; the RAM holds 2**data_depth words.
- data_width, 5, signed data word width.
- len_width, data_depth+1, burst length width; one full-memory burst (2**data_depth) is legal.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_base  in  data_depth  first address.
- cmd_len  in  len_width  element count; 0 is legal.
- cmd_stride  in  data_depth  address increment, unsigned, modulo 2**data_depth.
- mem_read  out  1  RAM read enable.
- mem_write  out  1  constant 0 (port kept for a direct bind to the RAM).
- mem_addr  out  data_depth  RAM address.
- mem_dataRead  in  data_width (signed)  RAM read data, valid the cycle after the sampling edge of mem_read.
- out_valid  out  1  stream data valid.
- out_ready  in  1  stream sink ready.
- out_data  out  data_width (signed)  stream data.
- out_last  out  1  marks the final element of a burst.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low, ports named clk and rst_n.
- Reset values: state IDLE; cmd_ready=1; mem_read=0; mem_addr=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; FIFO empty; in-flight flag 0.
- Reset mid-burst aborts the burst: nothing further is issued or emitted, and RAM contents are untouched.
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on cmd_valid&&cmd_ready:
  - latch addr=cmd_base, remaining=cmd_len, stride;
  - if cmd_len==0, go to DRAIN instead.
- Issue condition in RUN: remaining!=0 && (fifo_count + inflight - pop) < 2, where pop = out_valid&&out_ready.
  - mem_read and mem_addr are driven combinationally from the issue condition and the addr register.
- On an issue edge: addr <= (addr+stride) mod 2**data_depth; remaining--; inflight <= 1.
  - Without an issue, inflight <= 0.
- Data capture: mem_dataRead is pushed into a 2-entry FIFO on the edge after an issue edge, with last=1 when it is the final element.
- RUN -> DRAIN on the edge that issues the final read.
- DRAIN -> IDLE when inflight==0, the FIFO is empty, and the last element has been handshaken (or immediately for len 0).
  - done pulses for exactly the cycle after that transition edge (first cycle back in IDLE).
- Latency: command accepted at edge E0 -> mem_read high during the following cycle -> RAM samples at E1 -> FIFO push at E2 -> out_valid high after E2.
  - Two cycles from command accept to first valid.
- Throughput: 1 element/cycle with out_ready held high.
- Backpressure:
  - out_data and out_last hold stable while out_valid&&!out_ready.
  - The credit rule guarantees FIFO occupancy ≤ 2 with no overflow and no dropped RAM data.
- Simultaneous push and pop is allowed and leaves occupancy unchanged.
- Address wrap: modulo 2**data_depth; no error is flagged.
- cmd_valid while busy is ignored (cmd_ready=0).
- out_last is set only on the element with remaining==1 at issue.
  - For len 0 there is no stream beat, only done.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, RUN, DRAIN};
  - localparam FIFO_DEPTH=2.
- Sub-module stream_skid_fifo, parameterised on width:
  - 2 entries carrying {last, data};
  - push/pop/count/head outputs;
  - asynchronous active-low reset.
- The reader holds the FSM, address/remaining counters and credit logic.

Test Plan:
- RAM preloaded mem[i]=i; cmd base=3, len=4, stride=1, out_ready=1:
  - mem_addr sequence is 3,4,5,6 on consecutive cycles;
  - out_data is 3,4,5,6 with out_last only on 6;
  - first out_valid is 2 cycles after accept;
  - done pulses once.
- Wrap: base=30, len=3, stride=2 (depth 5):
  - addresses 30,0,2; outputs 30,0,2;
  - no spurious reads.
- Backpressure: len=6, out_ready low for 5 cycles after the first valid:
  - mem_read stops once FIFO+inflight=2;
  - out_data stays stable;
  - after release, all 6 values arrive in order, no loss or duplication.
- len=0:
  - cmd accepted, no mem_read, no out_valid;
  - done pulses and cmd_ready is high again within 2 cycles.
- Reset mid-burst (rst_n low after 2 beats of a len=8 burst, asynchronously between edges):
  - all outputs go to reset values immediately;
  - a fresh cmd base=0, len=2 then returns 0,1 correctly.
- Command while busy: cmd_valid held during a burst is not accepted until IDLE; back-to-back bursts produce no gap corruption.

Source files
------------

// File: rtl/mem_burst_reader_pkg.sv
// Shared types and sizing for the burst reader and its output FIFO.
// The FIFO depth of two matches the read credit limit enforced by the reader.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;
    localparam int FIFO_CNT_W = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_burst_reader_fifo.sv
// Two-entry FIFO carrying {last, data} beats from RAM capture to the output stream.
// A push and a pop in the same cycle leave the occupancy unchanged.
module stream_skid_fifo
    import mem_pkg::*;
#(
    parameter int width = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [width-1:0]      i_data,
    output logic [width-1:0]      o_head,
    output logic [FIFO_CNT_W-1:0] o_count
);

    logic [width-1:0]      r_mem [FIFO_DEPTH];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [FIFO_CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != FIFO_CNT_W'(FIFO_DEPTH)) || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/mem_burst_reader.sv
// Burst read initiator for the single-port synchronous RAM: one read per element,
// data returned as a valid/ready stream with a last marker and backpressure credit.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | issuing reads while elements remain and credit allows
// DRAIN | all reads issued, waiting for the final beat to leave the FIFO
module mem_burst_reader
    import mem_pkg::*;
#(
    parameter int data_depth = 5,
    parameter int data_width = 5,
    parameter int len_width  = data_depth + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [data_depth-1:0]        cmd_base,
    input  logic [len_width-1:0]         cmd_len,
    input  logic [data_depth-1:0]        cmd_stride,
    output logic                         mem_read,
    output logic                         mem_write,
    output logic [data_depth-1:0]        mem_addr,
    input  logic signed [data_width-1:0] mem_dataRead,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [data_width-1:0] out_data,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    state_t r_state;
    state_t w_next;

    logic [data_depth-1:0] r_addr;
    logic [data_depth-1:0] r_stride;
    logic [len_width-1:0]  r_remaining;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic                  r_done;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_issue;
    logic                  w_final_issue;
    logic [2:0]            w_occupancy;
    logic [FIFO_CNT_W-1:0] w_count;
    logic [data_width:0]   w_head;

    assign w_accept      = cmd_valid && (r_state == IDLE);
    assign w_pop         = out_valid && out_ready;
    // Credit counts FIFO entries plus the read in flight, net of the beat leaving now.
    assign w_occupancy   = 3'(w_count) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue       = (r_state == RUN) && (r_remaining != '0) && (w_occupancy < 3'd2);
    assign w_final_issue = w_issue && (r_remaining == len_width'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (cmd_len == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                if (w_final_issue) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_inflight && (w_count == '0)) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        busy      = (r_state == RUN) || (r_state == DRAIN);
        done      = r_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr          <= '0;
            r_stride        <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_final_issue;
            r_done          <= (r_state == DRAIN) && (w_next == IDLE);
            if (w_accept) begin
                r_addr      <= cmd_base;
                r_remaining <= cmd_len;
                r_stride    <= cmd_stride;
            end else if (w_issue) begin
                r_addr      <= r_addr + r_stride;
                r_remaining <= r_remaining - len_width'(1);
            end
        end
    end

    assign mem_read  = w_issue;
    assign mem_write = 1'b0;
    assign mem_addr  = r_addr;

    stream_skid_fifo #(
        .width (data_width + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_pop   (w_pop),
        .i_data  ({r_inflight_last, mem_dataRead}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    assign out_valid = (w_count != '0);
    assign out_data  = w_head[data_width-1:0];
    assign out_last  = w_head[data_width];

endmodule

// File: tb/tb_mem_burst_reader.sv
// Directed bench for mem_burst_reader with a behavioural RAM preloaded mem[i]=i;
// a negedge monitor records issued addresses, handshaken beats and done pulses.
module tb_mem_burst_reader;

    logic              clk;
    logic              rst_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [4:0]        cmd_base;
    logic [5:0]        cmd_len;
    logic [4:0]        cmd_stride;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        mem_addr;
    logic signed [4:0] mem_dataRead;
    logic              out_valid;
    logic              out_ready;
    logic signed [4:0] out_data;
    logic              out_last;
    logic              busy;
    logic              done;

    logic [4:0] ram [32];
    logic [4:0] d_u;
    int addr_q[$];
    int beat_q[$];
    int done_cnt;
    int checks;
    int errors;

    assign d_u = out_data;

    mem_burst_reader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_stride   (cmd_stride),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_dataRead (mem_dataRead),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_write) ram[mem_addr] <= d_u;
        if (mem_read) mem_dataRead <= ram[mem_addr];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_read) addr_q.push_back(int'(mem_addr));
            if (out_valid && out_ready) beat_q.push_back(int'(out_last) * 32 + int'(d_u));
            if (done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        addr_q.delete();
        beat_q.delete();
        done_cnt = 0;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_cmd(input int base, input int len, input int stride);
        int n;
        n = 0;
        cmd_base   = 5'(base);
        cmd_len    = 6'(len);
        cmd_stride = 5'(stride);
        cmd_valid  = 1'b1;
        @(negedge clk);
        while (!cmd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accept_timeout", int'(n < 300), 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready && n < 300);
        chk("idle_timeout", int'(n < 300), 1);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic check_addrs(input string tag, input int exp[$]);
        chk({tag, "_nreads"}, addr_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < addr_q.size(); i++)
            chk($sformatf("%s_addr%0d", tag, i), addr_q[i], exp[i]);
    endtask

    // Expected data listed in order; last must be set only on the final element.
    task automatic check_stream(input string tag, input int exp[$]);
        int e;
        chk({tag, "_nbeats"}, beat_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < beat_q.size(); i++) begin
            e = ((i == exp.size() - 1) ? 32 : 0) + (exp[i] & 31);
            chk($sformatf("%s_beat%0d", tag, i), beat_q[i], e);
        end
    endtask

    initial begin
        int q[$];
        int n;
        int ram_ok;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        for (int i = 0; i < 32; i++) ram[i] = 5'(i);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_base = '0;
        cmd_len = '0;
        cmd_stride = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_mem_read", int'(mem_read), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(d_u), 0);
        chk("rst_out_last", int'(out_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic burst: base 3, len 4, stride 1, with cycle-exact latency checks.
        clear_logs();
        send_cmd(3, 4, 1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("basic_rd%0d", k), int'(mem_read), 1);
            chk($sformatf("basic_addr%0d", k), int'(mem_addr), 3 + k);
            if (k < 2) chk($sformatf("basic_novalid%0d", k), int'(out_valid), 0);
            if (k == 2) begin
                chk("basic_first_valid", int'(out_valid), 1);
                chk("basic_first_data", int'(d_u), 3);
            end
        end
        @(negedge clk);
        chk("basic_rd_stop", int'(mem_read), 0);
        chk("basic_busy", int'(busy), 1);
        wait_idle();
        q = '{3, 4, 5, 6};
        check_addrs("basic", q);
        check_stream("basic", q);
        chk("basic_done_cnt", done_cnt, 1);

        // Address wrap modulo 32.
        clear_logs();
        send_cmd(30, 3, 2);
        wait_idle();
        q = '{30, 0, 2};
        check_addrs("wrap", q);
        check_stream("wrap", q);
        chk("wrap_done_cnt", done_cnt, 1);

        // Backpressure: sink stalls for 5 cycles once data appears.
        clear_logs();
        out_ready = 1'b0;
        send_cmd(8, 6, 1);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_valid%0d", k), int'(out_valid), 1);
            chk($sformatf("bp_hold_data%0d", k), int'(d_u), 8);
            chk($sformatf("bp_hold_last%0d", k), int'(out_last), 0);
            chk($sformatf("bp_no_read%0d", k), int'(mem_read), 0);
        end
        chk("bp_reads_before_release", addr_q.size(), 2);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle();
        q = '{8, 9, 10, 11, 12, 13};
        check_addrs("bp", q);
        check_stream("bp", q);
        chk("bp_done_cnt", done_cnt, 1);

        // Zero-length command: only a done pulse.
        clear_logs();
        send_cmd(5, 0, 1);
        @(negedge clk);
        chk("len0_busy", int'(busy), 1);
        chk("len0_cmd_ready_low", int'(cmd_ready), 0);
        @(negedge clk);
        chk("len0_done", int'(done), 1);
        chk("len0_cmd_ready", int'(cmd_ready), 1);
        @(negedge clk);
        chk("len0_done_once", int'(done), 0);
        chk("len0_no_reads", addr_q.size(), 0);
        chk("len0_no_beats", beat_q.size(), 0);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a len 8 burst.
        clear_logs();
        send_cmd(0, 8, 1);
        n = 0;
        while (beat_q.size() < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rstmid_beats_timeout", int'(n < 50), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_out_valid", int'(out_valid), 0);
        chk("rstmid_mem_read", int'(mem_read), 0);
        chk("rstmid_mem_addr", int'(mem_addr), 0);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_cmd_ready", int'(cmd_ready), 1);
        chk("rstmid_out_data", int'(d_u), 0);
        chk("rstmid_out_last", int'(out_last), 0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ram_ok = 1;
        for (int i = 0; i < 32; i++) if (ram[i] !== 5'(i)) ram_ok = 0;
        chk("rstmid_ram_intact", ram_ok, 1);
        @(posedge clk);
        #1;
        clear_logs();
        send_cmd(0, 2, 1);
        wait_idle();
        q = '{0, 1};
        check_addrs("after_rst", q);
        check_stream("after_rst", q);

        // Command held while busy, then back-to-back bursts.
        clear_logs();
        send_cmd(16, 3, 1);
        cmd_base = 5'd20;
        cmd_len = 6'd2;
        cmd_stride = 5'd3;
        cmd_valid = 1'b1;
        @(negedge clk);
        chk("busy_cmd_ready_low", int'(cmd_ready), 0);
        chk("busy_flag", int'(busy), 1);
        send_cmd(20, 2, 3);
        wait_idle();
        q = '{16, 17, 18, 20, 23};
        check_addrs("b2b", q);
        chk("b2b_nbeats", beat_q.size(), 5);
        if (beat_q.size() == 5) begin
            chk("b2b_beat0", beat_q[0], 16);
            chk("b2b_beat1", beat_q[1], 17);
            chk("b2b_beat2", beat_q[2], 32 + 18);
            chk("b2b_beat3", beat_q[3], 20);
            chk("b2b_beat4", beat_q[4], 32 + 23);
        end
        chk("b2b_done_cnt", done_cnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
